// File: rtl/debugger_tx.sv
// -----------------------------------------------------------------------------
// debugger_tx
//
// Purpose:
//   Downstream stage of the debugger receive path. A one-cycle sendSignal
//   strobe latches a NUM_BYTES-byte frame. The frame is then pushed byte by
//   byte into the UART transmit FIFO, least-significant byte first. The stage
//   stalls while the FIFO reports full. It reports busy while the frame is held
//   and pulses done for one cycle once the final byte has been written.
//
// Ports:
//   clock       system clock; all state changes on the rising edge
//   reset       asynchronous, active-high reset
//   sendSignal  one-cycle frame-valid strobe (sampled only when idle)
//   sendData    frame; byte k = sendData[DATA_W*k +: DATA_W]
//   tx_full     UART TX FIFO full flag
//   w_data      byte presented to the TX FIFO (low byte of the shift buffer)
//   wr_uart     TX FIFO write strobe; one byte is written per high cycle
//   busy        high while a frame is being sent
//   done        one-cycle pulse after the final byte has been written
//
// Parameter constraint: 2**CNT_W must exceed NUM_BYTES.
// -----------------------------------------------------------------------------
module debugger_tx #(
    parameter int NUM_BYTES = 220,
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          sendSignal,
    input  logic [NUM_BYTES*DATA_W-1:0]   sendData,
    input  logic                          tx_full,
    output logic [DATA_W-1:0]             w_data,
    output logic                          wr_uart,
    output logic                          busy,
    output logic                          done
);

    localparam int FRAME_W = NUM_BYTES * DATA_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [FRAME_W-1:0] buf_reg,   buf_next;
    logic [CNT_W-1:0]   cnt_reg,   cnt_next;

    // The buffer shifted down by one byte, with zero fill at the top. Because
    // of the shift, the byte being offered is always in the low DATA_W bits.
    // The buffer is empty (all zero) again once a frame has drained.
    logic [FRAME_W-1:0] buf_shifted;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi = gi + 1) begin : g_shift
            if (gi < NUM_BYTES - 1) begin : g_move
                assign buf_shifted[gi*DATA_W +: DATA_W] = buf_reg[(gi+1)*DATA_W +: DATA_W];
            end else begin : g_fill
                assign buf_shifted[gi*DATA_W +: DATA_W] = '0;
            end
        end
    endgenerate

    // State register. Reset clears the buffer, so w_data is defined (zero) at
    // the moment reset is asserted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            buf_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            buf_reg   <= buf_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state and outputs. wr_uart follows tx_full combinationally, so a
    // cycle with the FIFO not full always both writes and advances the buffer.
    // As a result, no byte is skipped or repeated under any stall pattern.
    always_comb begin
        state_next = state_reg;
        buf_next   = buf_reg;
        cnt_next   = cnt_reg;
        wr_uart    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (sendSignal) begin
                    buf_next   = sendData;
                    cnt_next   = '0;
                    state_next = S_SEND;
                end
            end

            S_SEND: begin
                busy    = 1'b1;
                wr_uart = !tx_full;
                if (!tx_full) begin
                    buf_next = buf_shifted;
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_IDX) begin
                        state_next = S_DONE;
                    end
                end
            end

            S_DONE: begin
                // The strobe is ignored here. A new frame can only be accepted
                // after the return to IDLE.
                done       = 1'b1;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign w_data = buf_reg[DATA_W-1:0];

endmodule

// File: doc/debugger_tx.md
Name: debugger_tx

Overview:
- Downstream stage of the debugger receive path.
- Accepts a one-cycle `sendSignal` strobe with a 1760-bit `sendData` frame (220 bytes) and latches the frame.
- Serialises the frame byte-by-byte into the UART transmit FIFO via `w_data`/`wr_uart`, honouring `tx_full` back-pressure.
- Reports `busy` while transferring and pulses `done` when the last byte has been written.

Parameters:
- NUM_BYTES, 220, number of bytes per frame.
- DATA_W, 8, bits per byte / UART word.
- CNT_W, 8, byte counter width; must satisfy 2^CNT_W > NUM_BYTES.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- sendSignal  input  1  one-cycle frame-valid strobe from the receive stage.
- sendData  input  NUM_BYTES*DATA_W (1760)  frame; byte k = sendData[8k+7:8k].
- tx_full  input  1  UART TX FIFO full flag.
- w_data  output  DATA_W  byte presented to the UART TX FIFO.
- wr_uart  output  1  TX FIFO write strobe; one byte is written per cycle it is high.
- busy  output  1  high while a frame is held or being sent.
- done  output  1  one-cycle pulse after the final byte is written.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, frame buffer=0, byte counter=0.
  - busy=0, done=0, wr_uart=0, w_data=0.
  - Reset asserted mid-frame abandons the frame immediately; no further writes occur.
- States: IDLE, SEND, DONE.
- IDLE:
  - busy=0, wr_uart=0.
  - On a rising edge with sendSignal=1: latch sendData into the buffer, counter<=0, go to SEND.
  - sendSignal is sampled only in IDLE.
- SEND:
  - busy=1, w_data=buffer[7:0] (combinational from the buffer).
  - wr_uart = !tx_full (combinational, same cycle).
  - Edge with tx_full=0: buffer shifts right by DATA_W, zero-filled; counter increments.
  - Edge with tx_full=1: buffer and counter hold; w_data stays stable.
  - When a write occurs with counter==NUM_BYTES-1: go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, wr_uart=0.
  - Unconditionally return to IDLE.
  - sendSignal in the DONE cycle is ignored.
- Byte order: LSB byte first (byte 0 = sendData[7:0]), byte 219 last.
- Latency: with sendSignal high in cycle N and tx_full low throughout:
  - wr_uart is high in cycles N+1..N+220 (220 writes).
  - done is high in cycle N+221.
  - The earliest next frame is accepted at the edge ending cycle N+222 (IDLE).
- sendSignal while busy (SEND or DONE) is ignored. The in-flight buffer is never overwritten, and no queueing occurs.
- tx_full toggling:
  - Each low cycle transfers exactly one byte.
  - No byte is skipped or duplicated regardless of the stall pattern.
  - A stall on the final byte delays done accordingly.
- wr_uart never asserts outside SEND. w_data is don't-care when wr_uart=0, but must not be X after reset.

Test Plan:
- Nominal frame: sendData byte k = k (8'h00..8'hDB), pulse sendSignal in cycle N, tx_full=0 -> wr_uart high N+1..N+220, w_data sequence 00,01,..,DB, done high only in cycle N+221, busy high N+1..N+220.
- Replicated pattern: sendData={220{8'h06}} -> exactly 220 writes, all w_data=8'h06, single done pulse.
- Back-pressure: byte k = k, tx_full high for 3 cycles starting at the write of byte 5 and high every other cycle from byte 100 on -> sequence still 00..DB with no gaps or repeats; wr_uart never high while tx_full high; done one cycle after the 220th write.
- Busy rejection: second sendSignal with sendData={220{8'hFF}} at N+50 and in the done cycle -> first frame output unchanged, no FF bytes emitted, state returns to IDLE with 220 total writes.
- Reset mid-frame: assert reset asynchronously (between edges) after 37 writes -> wr_uart, busy, done, w_data go 0 immediately; after release, no writes until a new sendSignal; a fresh frame then sends all 220 bytes from byte 0.
- Back-to-back frames: frame A (byte k = k), then sendSignal for frame B ({220{8'hA5}}) in the first IDLE cycle after done -> 440 writes total, A fully before B, two done pulses.
